cache_req_master: RTL and testbench
===================================

# cache_req_master

Request initiator for the 4-entry, 2-bit tiny cache. It queues host read/write commands in a small FIFO and issues them to the cache one at a time as single-cycle request pulses. After a fixed response latency it samples the cache's hit/data outputs and returns each result through a valid/ready handshake. It sits between host-side stimulus logic and the cache's request port, driving exactly the signals the cache samples: valid, rw, 2-bit address, 2-bit write data.

## Interface
- `CMD_DEPTH`, default 4: command FIFO depth; power of two, 2..16.
- `RSP_LAT`, default 1: cycles from the edge where the cache samples a request to the edge where this block samples hit/data; range 1..4.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  FIFO not full (registered).
- `cmd_rw`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  2  cache address.
- `cmd_wdata`  in  2  write data (ignored for reads).
- `req_valid`  out  1  request pulse to cache.
- `req_rw`, `req_addr[1:0]`, `req_wdata[1:0]`  out  request fields to cache.
- `rsp_hit`  in  1  cache hit flag.
- `rsp_rdata`  in  2  cache read data.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  host accepts result.
- `res_hit`, `res_rw`, `res_addr[1:0]`, `res_rdata[1:0]`  out  result fields.
- `busy`  out  1  FSM not in IDLE or FIFO non-empty.
- `hit_cnt`, `miss_cnt`  out  8 each  saturating statistics.

## Operation
- Push when `cmd_valid && cmd_ready`. Push while full is impossible because `cmd_ready` is 0. Push and pop in the same cycle are both allowed.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, FIFO non-empty: pop the head, load the `req_*` registers, `req_valid` <= 1, go to ISSUE.
- ISSUE: lasts exactly one cycle; `req_valid` <= 0; load the wait counter with RSP_LAT-1; go to WAIT.
- WAIT: when the counter is 0, capture into the `res_*` registers, `res_valid` <= 1, go to RESP. Otherwise decrement.
  - `res_hit` = `rsp_hit`.
  - `res_rdata` = `rsp_rdata` if read and hit, else 2'b00.
  - `res_rw` and `res_addr` echo the issued command.
- RESP: hold all `res_*` stable until `res_ready`. Then `res_valid` <= 0 and go to IDLE. The FIFO keeps accepting commands meanwhile.
- Only one request is outstanding at a time. `req_valid` is never high on two consecutive cycles.
- `req_rw`, `req_addr` and `req_wdata` hold their last values when `req_valid` is 0.
- Stats update at the capture edge:
  - `rsp_hit` = 1: `hit_cnt` += 1.
  - `rsp_hit` = 0: `miss_cnt` += 1.
  - Both saturate at 255.

## Timing
- Reset values:
  - `req_valid`, `req_rw`, `req_addr`, `req_wdata` = 0.
  - `res_valid`, `res_hit`, `res_rw`, `res_addr`, `res_rdata` = 0.
  - `hit_cnt`, `miss_cnt` = 0; `busy` = 0.
  - FIFO empty, `cmd_ready` = 1, FSM in IDLE.
- Latency, command accepted at edge E0 into an empty FIFO with FSM in IDLE:
  - `req_valid` high during E1..E2.
  - Cache samples at E2.
  - Capture at E(2+RSP_LAT); `res_valid` high after that edge.
- Result-to-next-issue: `res_ready` high at edge Ek leads to IDLE, and `req_valid` for the next queued command rises at Ek+1.
- Back-to-back throughput with `res_ready` tied high: one command per 3+RSP_LAT cycles.
- `rst` asserted in any state takes effect at the next edge:
  - All outputs return to reset values.
  - Queued commands and any in-flight response are discarded.
- `cmd_ready` reflects the count at the start of the cycle. A pop in the same cycle does not raise it early.

## Configuration
- `CACHE_REQ_STATS_EN` defined: `hit_cnt` and `miss_cnt` counters are implemented as described above.
- `CACHE_REQ_STATS_EN` undefined:
  - Counter registers are not built; `hit_cnt` and `miss_cnt` are constant 0.
  - Ports remain present.
  - All other behaviour is identical.

## Test plan
- Reset, then write (addr 2, data 3), then read addr 2, with a cache model behind the block:
  - Result 1: `res_hit`=0, `res_rw`=1, `res_rdata`=0.
  - Result 2: `res_hit`=1, `res_rdata`=3.
  - `req_valid` is high for exactly one cycle per command.
- Read addr 1 on an empty cache -> `res_hit`=0, `res_rdata`=0, `miss_cnt`=1.
- Push 5 commands with CMD_DEPTH=4 while `res_ready`=0:
  - `cmd_ready` drops after the 4th queued entry.
  - `res_valid` is held with stable fields.
  - After `res_ready` pulses, all remaining results return in order.
- RSP_LAT=3: cache model drives a hit exactly 3 cycles after sampling -> captured correctly; a model that is 1 cycle early shows a mismatch.
- Assert `rst` during WAIT -> next cycle:
  - `res_valid`=0, `busy`=0, `cmd_ready`=1, counters 0.
  - No further `req_valid`.
- 300 hitting reads with `CACHE_REQ_STATS_EN` defined -> `hit_cnt`=255 (saturated). With the macro undefined -> `hit_cnt`=0.

Source files
------------

// File: rtl/cache_req_master.sv
// cache_req_master: queues host read/write commands, issues them one at a time
// to the 4-entry tiny cache as single-cycle request pulses, samples hit/data
// RSP_LAT cycles later and returns the result through a valid/ready handshake.
// Optional feature macro: CACHE_REQ_STATS_EN builds the saturating hit/miss
// counters; without it hit_cnt/miss_cnt are tied to zero.
module cache_req_master #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [1:0] cmd_addr,
  input  logic [1:0] cmd_wdata,
  output logic       req_valid,
  output logic       req_rw,
  output logic [1:0] req_addr,
  output logic [1:0] req_wdata,
  input  logic       rsp_hit,
  input  logic [1:0] rsp_rdata,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_hit,
  output logic       res_rw,
  output logic [1:0] res_addr,
  output logic [1:0] res_rdata,
  output logic       busy,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt
);

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DATA_W  = 2;
  localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned PTR_W   = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W   = $clog2(CMD_DEPTH + 1);
  localparam int unsigned LAT_W   = 2;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RSP_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [ENTRY_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               push;

  logic               pop;
  logic               lat_load;
  logic               capture;
  logic               res_done;
  logic [LAT_W-1:0]   wait_cnt;

  assign push       = cmd_valid && cmd_ready;
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: one request in flight, result must be accepted before the next issue
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_cnt == '0) state_next = RESP;
      RESP:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: per-state control strobes for the datapath
  always_comb begin
    pop      = 1'b0;
    lat_load = 1'b0;
    capture  = 1'b0;
    res_done = 1'b0;
    unique case (state)
      IDLE:    pop      = !fifo_empty;
      ISSUE:   lat_load = 1'b1;
      WAIT:    capture  = (wait_cnt == '0);
      RESP:    res_done = res_ready;
      default: pop      = 1'b0;
    endcase
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Command storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
    end
  end

  // FIFO pointers, occupancy, registered ready and busy flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      cmd_ready <= (count_next != FULL_CNT);
      busy      <= (state_next != IDLE) || (count_next != '0);
    end
  end

  // Request pulse and fields; fields hold between requests
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid <= 1'b0;
      req_rw    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      req_valid <= pop;
      if (pop) begin
        {req_rw, req_addr, req_wdata} <= head;
      end
    end
  end

  // Response latency counter, loaded while the cache samples the request
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (lat_load) begin
      wait_cnt <= LAT_LOAD;
    end else if ((state == WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - LAT_W'(1);
    end
  end

  // Result capture; read data is only meaningful for a read that hit
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_rw    <= 1'b0;
      res_addr  <= '0;
      res_rdata <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_hit   <= rsp_hit;
      res_rw    <= req_rw;
      res_addr  <= req_addr;
      res_rdata <= (!req_rw && rsp_hit) ? rsp_rdata : DATA_W'(0);
    end else if (res_done) begin
      res_valid <= 1'b0;
    end
  end

`ifdef CACHE_REQ_STATS_EN
  localparam int unsigned STAT_W = 8;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Saturating hit/miss statistics, updated on the capture edge
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (capture) begin
      if (rsp_hit) begin
        if (hit_cnt != STAT_MAX) hit_cnt <= hit_cnt + STAT_W'(1);
      end else begin
        if (miss_cnt != STAT_MAX) miss_cnt <= miss_cnt + STAT_W'(1);
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_req_master.sv
// Directed self-checking bench for cache_req_master: a default instance
// (CMD_DEPTH=4, RSP_LAT=1) behind a tiny-cache model, and an RSP_LAT=3
// instance behind a single-cycle hit-pulse model with selectable delay.
module tb_cache_req_master;

`ifdef CACHE_REQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [1:0] cmd_addr = 2'b00;
  logic [1:0] cmd_wdata = 2'b00;
  logic       req_valid, req_rw;
  logic [1:0] req_addr, req_wdata;
  logic       rsp_hit;
  logic [1:0] rsp_rdata;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_hit, res_rw;
  logic [1:0] res_addr, res_rdata;
  logic       busy;
  logic [7:0] hit_cnt, miss_cnt;

  logic       l3_cmd_valid = 1'b0;
  logic       l3_cmd_ready;
  logic       l3_cmd_rw = 1'b0;
  logic [1:0] l3_cmd_addr = 2'b00;
  logic [1:0] l3_cmd_wdata = 2'b00;
  logic       l3_req_valid, l3_req_rw;
  logic [1:0] l3_req_addr, l3_req_wdata;
  logic       l3_rsp_hit;
  logic [1:0] l3_rsp_rdata;
  logic       l3_res_valid;
  logic       l3_res_ready = 1'b1;
  logic       l3_res_hit, l3_res_rw;
  logic [1:0] l3_res_addr, l3_res_rdata;
  logic       l3_busy;
  logic [7:0] l3_hit_cnt, l3_miss_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int n_tmo = 0;

  cache_req_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_hit(rsp_hit), .rsp_rdata(rsp_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_rw(res_rw),
    .res_addr(res_addr), .res_rdata(res_rdata),
    .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  cache_req_master #(.CMD_DEPTH(4), .RSP_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready), .cmd_rw(l3_cmd_rw),
    .cmd_addr(l3_cmd_addr), .cmd_wdata(l3_cmd_wdata),
    .req_valid(l3_req_valid), .req_rw(l3_req_rw), .req_addr(l3_req_addr),
    .req_wdata(l3_req_wdata),
    .rsp_hit(l3_rsp_hit), .rsp_rdata(l3_rsp_rdata),
    .res_valid(l3_res_valid), .res_ready(l3_res_ready), .res_hit(l3_res_hit),
    .res_rw(l3_res_rw), .res_addr(l3_res_addr), .res_rdata(l3_res_rdata),
    .busy(l3_busy), .hit_cnt(l3_hit_cnt), .miss_cnt(l3_miss_cnt)
  );

  initial forever #5 clk = ~clk;

  // Tiny cache model: registered response one edge after sampling; write allocates.
  // Unwritten lines hold 2'b01 so that masking of miss/write data is visible.
  logic [3:0] c_vld;
  logic [1:0] c_dat [4];
  always @(posedge clk) begin
    if (rst) begin
      c_vld <= '0;
      for (int i = 0; i < 4; i++) c_dat[i] <= 2'b01;
      rsp_hit   <= 1'b0;
      rsp_rdata <= 2'b00;
    end else if (req_valid) begin
      rsp_hit   <= c_vld[req_addr];
      rsp_rdata <= c_dat[req_addr];
      if (req_rw) begin
        c_vld[req_addr] <= 1'b1;
        c_dat[req_addr] <= req_wdata;
      end
    end
  end

  // Hit-pulse model for the RSP_LAT=3 instance: hit is high for one cycle,
  // l3_sel+1 cycles after the request is sampled (l3_sel=2 is on time).
  logic [2:0] l3_sr;
  logic [1:0] l3_sel = 2'd2;
  always @(posedge clk) begin
    if (rst) l3_sr <= '0;
    else     l3_sr <= {l3_sr[1:0], l3_req_valid};
  end
  assign l3_rsp_hit   = l3_sr[l3_sel];
  assign l3_rsp_rdata = l3_rsp_hit ? 2'b10 : 2'b00;

  // Request-pulse monitor for the default instance
  int   cyc = 0;
  int   req_cnt = 0;
  int   consec_err = 0;
  logic prev_rv = 1'b0;
  int   rv_stamp[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid === 1'b1) begin
      req_cnt <= req_cnt + 1;
      rv_stamp.push_back(cyc);
      if (prev_rv) consec_err <= consec_err + 1;
    end
    prev_rv <= (req_valid === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at time %0t, want finished", $time);
    $fatal(1, "global timeout");
  end

  // ---------------- stimulus helpers (all start and end at a negedge) ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic rw, input logic [1:0] a, input logic [1:0] d);
    int g = 0;
    while (cmd_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (cmd_ready !== 1'b1) n_tmo++;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    int g = 0;
    while (res_valid !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    ok = (res_valid === 1'b1);
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int g = 0;
    while ((busy !== 1'b0 || res_valid !== 1'b0) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    ok = (busy === 1'b0 && res_valid === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_valid, req_rw, req_addr, req_wdata, res_valid, res_hit, res_rw, res_addr,
         res_rdata, busy, cmd_ready} !== 15'b000000_0000000_0_1) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", {req_valid, req_rw, req_addr, req_wdata,
               res_valid, res_hit, res_rw, res_addr, res_rdata, busy, cmd_ready}, 15'b000000000000001);
    end
    n_cmp++;
    if ({hit_cnt, miss_cnt} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_counters: got %h want 0000", {hit_cnt, miss_cnt});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, cmd_ready, req_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want 010", {busy, cmd_ready, req_valid});
    end
  endtask

  task automatic test_write_read();
    bit ok;
    int r0;
    do_reset();
    r0 = req_cnt;
    push(1'b1, 2'd2, 2'd3);
    n_cmp++;
    if ({req_valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_after_accept: got req_valid,busy=%b want 01", {req_valid, busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({req_valid, req_rw, req_addr, req_wdata} !== 6'b1_1_10_11) begin
      n_fail++;
      $display("FAIL wr_issue_fields: got %b want 111011", {req_valid, req_rw, req_addr, req_wdata});
    end
    @(negedge clk);
    n_cmp++;
    if ({req_valid, res_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_pulse_end: got req_valid,res_valid=%b want 00", {req_valid, res_valid});
    end
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_capture_latency: got res_valid=%b want 1", res_valid);
    end
    n_cmp++;
    if ({res_hit, res_rw, res_addr, res_rdata} !== 6'b0_1_10_00) begin
      n_fail++;
      $display("FAIL wr_result: got %b want 011000", {res_hit, res_rw, res_addr, res_rdata});
    end
    take_res();
    push(1'b0, 2'd2, 2'd0);
    wait_res(ok);
    n_cmp++;
    if (!ok || {res_hit, res_rw, res_addr, res_rdata} !== 6'b1_0_10_11) begin
      n_fail++;
      $display("FAIL rd_hit_result: got valid=%b fields=%b want valid=1 fields=101011",
               res_valid, {res_hit, res_rw, res_addr, res_rdata});
    end
    take_res();
    push(1'b1, 2'd2, 2'd1);
    wait_res(ok);
    n_cmp++;
    if (!ok || {res_hit, res_rw, res_addr, res_rdata} !== 6'b1_1_10_00) begin
      n_fail++;
      $display("FAIL wr_hit_result: got valid=%b fields=%b want valid=1 fields=111000",
               res_valid, {res_hit, res_rw, res_addr, res_rdata});
    end
    take_res();
    wait_idle(ok);
    n_cmp++;
    if (!ok || (req_cnt - r0) !== 3) begin
      n_fail++;
      $display("FAIL wr_rd_req_pulses: got idle=%b pulses=%0d want idle=1 pulses=3", ok, req_cnt - r0);
    end
    n_cmp++;
    if ({hit_cnt, miss_cnt} !== (STATS ? {8'd2, 8'd1} : 16'h0000)) begin
      n_fail++;
      $display("FAIL wr_rd_stats: got hit=%0d miss=%0d want hit=%0d miss=%0d",
               hit_cnt, miss_cnt, STATS ? 2 : 0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_read_miss();
    bit ok;
    do_reset();
    push(1'b0, 2'd1, 2'd0);
    wait_res(ok);
    n_cmp++;
    if (!ok || {res_hit, res_rw, res_addr, res_rdata} !== 6'b0_0_01_00) begin
      n_fail++;
      $display("FAIL rd_miss_result: got valid=%b fields=%b want valid=1 fields=000100",
               res_valid, {res_hit, res_rw, res_addr, res_rdata});
    end
    take_res();
    n_cmp++;
    if ({hit_cnt, miss_cnt} !== (STATS ? {8'd0, 8'd1} : 16'h0000)) begin
      n_fail++;
      $display("FAIL rd_miss_stats: got hit=%0d miss=%0d want hit=0 miss=%0d",
               hit_cnt, miss_cnt, STATS ? 1 : 0);
    end
  endtask

  task automatic test_fifo_full();
    logic       e_rw   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] e_addr [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd3};
    logic [1:0] e_wd   [5] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
    logic [5:0] e_res  [5] = '{6'b010000, 6'b010100, 6'b100001, 6'b100110, 6'b001100};
    bit ok;
    int r0;
    do_reset();
    res_ready = 1'b0;
    r0 = req_cnt;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fifo_ready_before_push%0d: got %b want 1", i, cmd_ready);
      end
      push(e_rw[i], e_addr[i], e_wd[i]);
    end
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full_ready: got %b want 0", cmd_ready);
    end
    n_cmp++;
    if ({res_valid, res_hit, res_rw, res_addr, res_rdata} !== {1'b1, e_res[0]}) begin
      n_fail++;
      $display("FAIL fifo_first_result: got %b want %b",
               {res_valid, res_hit, res_rw, res_addr, res_rdata}, {1'b1, e_res[0]});
    end
    // A sixth command is offered while full and must not be taken
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_addr  = 2'd2;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, res_valid, res_hit, res_rw, res_addr, res_rdata} !== {2'b01, e_res[0]}) begin
      n_fail++;
      $display("FAIL fifo_hold_stable: got %b want %b",
               {cmd_ready, res_valid, res_hit, res_rw, res_addr, res_rdata}, {2'b01, e_res[0]});
    end
    cmd_valid = 1'b0;
    take_res();
    n_cmp++;
    if ({cmd_ready, req_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL fifo_release_edge: got ready,req_valid=%b want 00", {cmd_ready, req_valid});
    end
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, req_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL fifo_next_issue: got ready,req_valid=%b want 11", {cmd_ready, req_valid});
    end
    for (int i = 1; i < 5; i++) begin
      wait_res(ok);
      n_cmp++;
      if (!ok || {res_hit, res_rw, res_addr, res_rdata} !== e_res[i]) begin
        n_fail++;
        $display("FAIL fifo_result%0d: got valid=%b fields=%b want valid=1 fields=%b",
                 i, res_valid, {res_hit, res_rw, res_addr, res_rdata}, e_res[i]);
      end
      take_res();
    end
    wait_idle(ok);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (!ok || res_valid !== 1'b0 || (req_cnt - r0) !== 5) begin
      n_fail++;
      $display("FAIL fifo_drain: got idle=%b res_valid=%b pulses=%0d want idle=1 res_valid=0 pulses=5",
               ok, res_valid, req_cnt - r0);
    end
    n_cmp++;
    if ({hit_cnt, miss_cnt} !== (STATS ? {8'd2, 8'd3} : 16'h0000)) begin
      n_fail++;
      $display("FAIL fifo_stats: got hit=%0d miss=%0d want hit=%0d miss=%0d",
               hit_cnt, miss_cnt, STATS ? 2 : 0, STATS ? 3 : 0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int s0;
    do_reset();
    res_ready = 1'b1;
    s0 = rv_stamp.size();
    for (int i = 0; i < 4; i++) push(1'b0, 2'(i), 2'd0);
    wait_idle(ok);
    res_ready = 1'b0;
    n_cmp++;
    if (!ok || (rv_stamp.size() - s0) !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: got idle=%b pulses=%0d want idle=1 pulses=4", ok, rv_stamp.size() - s0);
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if ((rv_stamp[s0 + i] - rv_stamp[s0 + i - 1]) !== 4) begin
          n_fail++;
          $display("FAIL b2b_spacing%0d: got %0d cycles want 4", i,
                   rv_stamp[s0 + i] - rv_stamp[s0 + i - 1]);
        end
      end
    end
  endtask

  task automatic test_rsp_lat3();
    int g;
    do_reset();
    l3_sel       = 2'd2;
    l3_cmd_valid = 1'b1;
    l3_cmd_rw    = 1'b0;
    l3_cmd_addr  = 2'd1;
    l3_cmd_wdata = 2'd3;
    @(negedge clk);
    l3_cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (l3_res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL lat3_early_valid_e%0d: got %b want 0", k, l3_res_valid);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({l3_res_valid, l3_res_hit, l3_res_rw, l3_res_addr, l3_res_rdata} !== 7'b1_1_0_01_10) begin
      n_fail++;
      $display("FAIL lat3_capture: got %b want 1100110",
               {l3_res_valid, l3_res_hit, l3_res_rw, l3_res_addr, l3_res_rdata});
    end
    n_cmp++;
    if ({l3_req_rw, l3_req_addr, l3_req_wdata} !== 5'b0_01_11) begin
      n_fail++;
      $display("FAIL lat3_req_fields: got %b want 00111", {l3_req_rw, l3_req_addr, l3_req_wdata});
    end
    repeat (2) @(negedge clk);
    // Cache answering one cycle early: the pulse is gone at the capture edge
    l3_sel       = 2'd1;
    l3_cmd_valid = 1'b1;
    l3_cmd_addr  = 2'd3;
    @(negedge clk);
    l3_cmd_valid = 1'b0;
    g = 0;
    while (l3_res_valid !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if ({l3_res_valid, l3_res_hit, l3_res_addr, l3_res_rdata} !== 6'b1_0_11_00) begin
      n_fail++;
      $display("FAIL lat3_early_model: got %b want 101100",
               {l3_res_valid, l3_res_hit, l3_res_addr, l3_res_rdata});
    end
    repeat (2) @(negedge clk);
    l3_sel = 2'd2;
    n_cmp++;
    if ({l3_busy, l3_cmd_ready, l3_hit_cnt, l3_miss_cnt} !==
        {2'b01, (STATS ? {8'd1, 8'd1} : 16'h0000)}) begin
      n_fail++;
      $display("FAIL lat3_final: got busy=%b ready=%b hit=%0d miss=%0d want busy=0 ready=1 hit=%0d miss=%0d",
               l3_busy, l3_cmd_ready, l3_hit_cnt, l3_miss_cnt, STATS ? 1 : 0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_rst_in_wait();
    int r1;
    do_reset();
    res_ready = 1'b0;
    push(1'b0, 2'd0, 2'd0);
    push(1'b1, 2'd3, 2'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({res_valid, busy, cmd_ready, req_valid} !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: got %b want 0010", {res_valid, busy, cmd_ready, req_valid});
    end
    n_cmp++;
    if ({hit_cnt, miss_cnt} !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_wait_counters: got %h want 0000", {hit_cnt, miss_cnt});
    end
    rst = 1'b0;
    r1 = req_cnt;
    repeat (8) @(negedge clk);
    n_cmp++;
    if ((req_cnt - r1) !== 0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_quiet: got pulses=%0d res_valid=%b busy=%b want 0 0 0",
               req_cnt - r1, res_valid, busy);
    end
  endtask

  task automatic test_stats_sat();
    bit ok;
    do_reset();
    res_ready = 1'b1;
    push(1'b1, 2'd0, 2'd2);
    for (int i = 0; i < 300; i++) push(1'b0, 2'd0, 2'd0);
    wait_idle(ok);
    res_ready = 1'b0;
    n_cmp++;
    if (!ok || hit_cnt !== (STATS ? 8'd255 : 8'd0)) begin
      n_fail++;
      $display("FAIL stats_hit_sat: got idle=%b hit=%0d want idle=1 hit=%0d", ok, hit_cnt, STATS ? 255 : 0);
    end
    n_cmp++;
    if (miss_cnt !== (STATS ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL stats_miss: got %0d want %0d", miss_cnt, STATS ? 1 : 0);
    end
  endtask

  task automatic test_monitors();
    n_cmp++;
    if (consec_err !== 0) begin
      n_fail++;
      $display("FAIL req_valid_consecutive: got %0d back-to-back pulses want 0", consec_err);
    end
    n_cmp++;
    if (n_tmo !== 0) begin
      n_fail++;
      $display("FAIL push_ready_timeouts: got %0d want 0", n_tmo);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_miss();
    test_fifo_full();
    test_back_to_back();
    test_rsp_lat3();
    test_rst_in_wait();
    test_stats_sat();
    test_monitors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
